cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control FSM for the Cortex-M0 core datapath. It steps each instruction through fetch, decode, execute and retire. It drives the datapath load enables and phase strobes from the status the datapath reports back (`update_flags`, `write_rd`, `ig_ex`, `br_en`). It also handles memory wait states, a fetch timeout fault and an external halt request.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum FETCH wait cycles without `mem_ready` before FAULT. Legal range 1–255.

Ports:
- `clk` input 1: single core clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mem_ready` input 1: instruction memory has valid IR this cycle.
- `halt_req` input 1: level request to park the core between instructions.
- `update_flags` input 1: datapath S bit; instruction writes APSR.
- `write_rd` input 1: datapath; instruction writes Rd.
- `ig_ex` input 1: datapath; condition failed, skip execute.
- `br_en` input 1: datapath; branch taken.
- `cu_decode` output 1: decode-phase strobe.
- `cu_execute` output 1: execute-phase strobe.
- `branch` output 1: PC source select = branch target.
- `ld_pc` output 1: PC load enable.
- `ld_lr` output 1: LR load enable.
- `ld_rd` output 1: Rd load enable.
- `ld_apsr` output 1: APSR load enable.
- `ld_sp`, `ld_ipsr`, `ld_primask`, `wr_en` output 1 each: held 0 in this revision; reserved for exception entry and stores.
- `halted` output 1: core parked in HALT.
- `fault` output 1: fetch timeout occurred; sticky.
- `state` output 3: current FSM state, for debug.
- `instr_count` output 32: retired-instruction count; present only with `CU_PERF_CNT_EN`.

## Operation
- State encoding: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, RETIRE=4, BRANCH=5, HALT=6, FAULT=7.
- All outputs are Moore outputs, decoded from the state register and two registered flags (`wb_rd`, `wb_flags`).
- RESET → FETCH unconditionally. No output is active.
- FETCH: the wait counter increments each cycle.
  - `halt_req`=1 → HALT. This has priority over `mem_ready`; no fetch is consumed.
  - Else `mem_ready`=1 → DECODE; the counter clears.
  - Else the counter reaching `MEM_TIMEOUT` → FAULT.
- DECODE: `cu_decode`=1.
  - `ig_ex`=1 → RETIRE with `wb_rd`=`wb_flags`=0 (skipped instruction).
  - Else → EXECUTE.
- EXECUTE: `cu_execute`=1. Sample `wb_rd`←`write_rd` and `wb_flags`←`update_flags`.
  - `br_en`=1 → BRANCH.
  - Else → RETIRE.
- RETIRE: `ld_pc`=1 (sequential PC), `ld_rd`=`wb_rd`, `ld_apsr`=`wb_flags`. Then → FETCH.
- BRANCH: `branch`=1, `ld_pc`=1, `ld_lr`=1 (the ALU supplies an unchanged LR for non-link branches), `ld_apsr`=`wb_flags`. Then → FETCH.
- HALT: `halted`=1, all loads 0. `halt_req`=0 → FETCH; otherwise stay.
- FAULT: `fault`=1, all loads 0. Left only by `rst`.
- Exactly one of {RETIRE, BRANCH} occurs per consumed fetch. `ld_pc` is never asserted in any other state.

## Timing
- Reset values: `state`=RESET, all outputs 0, wait counter 0, `wb_*`=0, `instr_count`=0.
- `rst` asserted in any state, including mid-instruction, HALT or FAULT: the next state is RESET and no load enable fires on that edge.
- Latency with `mem_ready` already high:
  - normal or branch instruction: 4 cycles (FETCH, DECODE, EXECUTE, RETIRE/BRANCH);
  - skipped instruction: 3 cycles.
- Each wait cycle in FETCH adds 1 cycle.
- Timeout: FAULT is entered on the edge ending the `MEM_TIMEOUT`-th consecutive non-ready FETCH cycle.
- `mem_ready` on that same cycle wins: → DECODE.
- `halt_req` is examined only in FETCH and HALT. An in-flight instruction always completes first.
- Datapath status inputs are sampled only in DECODE (`ig_ex`) and EXECUTE (`br_en`, `write_rd`, `update_flags`). They are ignored elsewhere.

## Configuration
- `CU_PERF_CNT_EN` defined:
  - `instr_count` port exists;
  - it increments by 1 on each RETIRE or BRANCH cycle that is not a skipped instruction;
  - it wraps from 0xFFFFFFFF to 0;
  - it is cleared by `rst`.
- `CU_PERF_CNT_EN` undefined: the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- Reset, then `mem_ready`=1 and `write_rd`=1, `update_flags`=0 in EXECUTE → `state` 0,1,2,3,4. `ld_rd`=1, `ld_pc`=1 and `ld_apsr`=0 in cycle 4. `instr_count`=1.
- `br_en`=1 in EXECUTE → BRANCH for 1 cycle with `branch`=`ld_pc`=`ld_lr`=1, then FETCH. `ld_rd` is never 1.
- `ig_ex`=1 in DECODE → DECODE→RETIRE with `ld_pc`=1, `ld_rd`=`ld_apsr`=0, no `cu_execute` pulse, `instr_count` unchanged.
- `MEM_TIMEOUT`=3 with `mem_ready` held 0 → FAULT after the 3rd FETCH cycle and `fault`=1 sticky. A separate run with `mem_ready`=1 on cycle 3 → DECODE.
- `halt_req`=1 raised during EXECUTE → the instruction retires, then HALT with `halted`=1. Dropping `halt_req` → FETCH on the next edge.
- `rst` pulsed in EXECUTE → RETIRE is never entered, all outputs 0 on the next cycle, `state`=0.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control/status bundle between the sequencer (master) and the datapath and memory (slave)
interface cpu_sequencer_if;
  logic       mem_ready;
  logic       halt_req;
  logic       update_flags;
  logic       write_rd;
  logic       ig_ex;
  logic       br_en;
  logic       cu_decode;
  logic       cu_execute;
  logic       branch;
  logic       ld_pc;
  logic       ld_lr;
  logic       ld_rd;
  logic       ld_apsr;
  logic       ld_sp;
  logic       ld_ipsr;
  logic       ld_primask;
  logic       wr_en;
  logic       halted;
  logic       fault;
  logic [2:0] state;
  modport master (
    input  mem_ready, halt_req, update_flags, write_rd, ig_ex, br_en,
    output cu_decode, cu_execute, branch, ld_pc, ld_lr, ld_rd, ld_apsr,
           ld_sp, ld_ipsr, ld_primask, wr_en, halted, fault, state
  );
  modport slave (
    output mem_ready, halt_req, update_flags, write_rd, ig_ex, br_en,
    input  cu_decode, cu_execute, branch, ld_pc, ld_lr, ld_rd, ld_apsr,
           ld_sp, ld_ipsr, ld_primask, wr_en, halted, fault, state
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute/retire control FSM; CU_PERF_CNT_EN adds the retired-instruction counter
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  cpu_sequencer_if.master  bus
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]      instr_count
`endif
);
  typedef enum logic [2:0] {
    RESET   = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    RETIRE  = 3'd4,
    BRANCH  = 3'd5,
    HALT    = 3'd6,
    FAULT   = 3'd7
  } state_t;
  state_t     st;
  logic [7:0] wait_cnt;
  logic       wb_rd;
  logic       wb_flags;
  logic       wb_stage;
  // state transitions, fetch wait counting and capture of the execute-phase write-back flags
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= RESET;
      wait_cnt <= '0;
      wb_rd    <= 1'b0;
      wb_flags <= 1'b0;
    end else begin
      case (st)
        RESET: st <= FETCH;
        FETCH: begin
          if (bus.halt_req) begin
            st       <= HALT;
            wait_cnt <= '0;
          end else if (bus.mem_ready) begin
            st       <= DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            st       <= FAULT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (bus.ig_ex) begin
            st       <= RETIRE;
            wb_rd    <= 1'b0;
            wb_flags <= 1'b0;
          end else begin
            st <= EXECUTE;
          end
        end
        EXECUTE: begin
          wb_rd    <= bus.write_rd;
          wb_flags <= bus.update_flags;
          st       <= bus.br_en ? BRANCH : RETIRE;
        end
        RETIRE:  st <= FETCH;
        BRANCH:  st <= FETCH;
        HALT:    st <= bus.halt_req ? HALT : FETCH;
        FAULT:   st <= FAULT;
        default: st <= RESET;
      endcase
    end
  end
  // the instruction-ending states; loads are suppressed on a reset edge so nothing commits as the core restarts
  assign wb_stage       = !rst && (st == RETIRE || st == BRANCH);
  assign bus.cu_decode  = st == DECODE;
  assign bus.cu_execute = st == EXECUTE;
  assign bus.branch     = st == BRANCH;
  assign bus.ld_pc      = wb_stage;
  assign bus.ld_lr      = wb_stage && st == BRANCH;
  assign bus.ld_rd      = wb_stage && st == RETIRE && wb_rd;
  assign bus.ld_apsr    = wb_stage && wb_flags;
  assign bus.ld_sp      = 1'b0;
  assign bus.ld_ipsr    = 1'b0;
  assign bus.ld_primask = 1'b0;
  assign bus.wr_en      = 1'b0;
  assign bus.halted     = st == HALT;
  assign bus.fault      = st == FAULT;
  assign bus.state      = st;
`ifdef CU_PERF_CNT_EN
  logic skipped;
  // count completed instructions, excluding those whose condition failed in decode
  always_ff @(posedge clk) begin
    if (rst) begin
      skipped     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (st == DECODE) skipped <= bus.ig_ex;
      if ((st == RETIRE || st == BRANCH) && !skipped) instr_count <= instr_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven directed bench for cpu_sequencer with MEM_TIMEOUT=3
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_sequencer_if bus();
`ifdef CU_PERF_CNT_EN
  logic [31:0] instr_count;
`endif
  cpu_sequencer #(.MEM_TIMEOUT(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CU_PERF_CNT_EN
    ,
    .instr_count(instr_count)
`endif
  );
  // {cu_decode, cu_execute, branch, ld_pc, ld_lr, ld_rd, ld_apsr, ld_sp, ld_ipsr, ld_primask, wr_en, halted, fault}
  localparam logic [12:0] O_NONE   = 13'b0000000000000;
  localparam logic [12:0] O_DEC    = 13'b1000000000000;
  localparam logic [12:0] O_EXE    = 13'b0100000000000;
  localparam logic [12:0] O_RET    = 13'b0001000000000;
  localparam logic [12:0] O_RET_RD = 13'b0001010000000;
  localparam logic [12:0] O_RET_RA = 13'b0001001000000;
  localparam logic [12:0] O_BR_A   = 13'b0011101000000;
  localparam logic [12:0] O_HALT   = 13'b0000000000010;
  localparam logic [12:0] O_FAULT  = 13'b0000000000001;
  logic [12:0] outs;
  assign outs = {bus.cu_decode, bus.cu_execute, bus.branch, bus.ld_pc, bus.ld_lr, bus.ld_rd, bus.ld_apsr,
                 bus.ld_sp, bus.ld_ipsr, bus.ld_primask, bus.wr_en, bus.halted, bus.fault};
  // in = {rst, mem_ready, halt_req, update_flags, write_rd, ig_ex, br_en}
  typedef struct {
    logic [6:0]  in;
    logic [2:0]  st;
    logic [12:0] out;
    int          cnt;
  } vec_t;
  vec_t tbl [37];
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [6:0] v);
    {rst, bus.mem_ready, bus.halt_req, bus.update_flags, bus.write_rd, bus.ig_ex, bus.br_en} = v;
  endtask
  task automatic step(input logic [6:0] v);
    drive(v);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cyc;
    tbl[0]  = '{7'b1000000, 3'd0, O_NONE,   0};
    tbl[1]  = '{7'b0100100, 3'd1, O_NONE,   0};
    tbl[2]  = '{7'b0100100, 3'd2, O_DEC,    0};
    tbl[3]  = '{7'b0100100, 3'd3, O_EXE,    0};
    tbl[4]  = '{7'b0100100, 3'd4, O_RET_RD, 0};
    tbl[5]  = '{7'b0100000, 3'd1, O_NONE,   1};
    tbl[6]  = '{7'b0100000, 3'd2, O_DEC,    1};
    tbl[7]  = '{7'b0100000, 3'd3, O_EXE,    1};
    tbl[8]  = '{7'b0101101, 3'd5, O_BR_A,   1};
    tbl[9]  = '{7'b0100000, 3'd1, O_NONE,   2};
    tbl[10] = '{7'b0100000, 3'd2, O_DEC,    2};
    tbl[11] = '{7'b0101111, 3'd4, O_RET,    2};
    tbl[12] = '{7'b0100000, 3'd1, O_NONE,   2};
    tbl[13] = '{7'b0000000, 3'd1, O_NONE,   2};
    tbl[14] = '{7'b0000000, 3'd1, O_NONE,   2};
    tbl[15] = '{7'b0100000, 3'd2, O_DEC,    2};
    tbl[16] = '{7'b0000000, 3'd3, O_EXE,    2};
    tbl[17] = '{7'b0001000, 3'd4, O_RET_RA, 2};
    tbl[18] = '{7'b0000000, 3'd1, O_NONE,   3};
    tbl[19] = '{7'b0100000, 3'd2, O_DEC,    3};
    tbl[20] = '{7'b0010000, 3'd3, O_EXE,    3};
    tbl[21] = '{7'b0010100, 3'd4, O_RET_RD, 3};
    tbl[22] = '{7'b0110000, 3'd1, O_NONE,   4};
    tbl[23] = '{7'b0110000, 3'd6, O_HALT,   4};
    tbl[24] = '{7'b0010000, 3'd6, O_HALT,   4};
    tbl[25] = '{7'b0000000, 3'd1, O_NONE,   4};
    tbl[26] = '{7'b0100000, 3'd2, O_DEC,    4};
    tbl[27] = '{7'b0100000, 3'd3, O_EXE,    4};
    tbl[28] = '{7'b1000000, 3'd0, O_NONE,   0};
    tbl[29] = '{7'b0100000, 3'd1, O_NONE,   0};
    tbl[30] = '{7'b0000000, 3'd1, O_NONE,   0};
    tbl[31] = '{7'b0000000, 3'd1, O_NONE,   0};
    tbl[32] = '{7'b0000000, 3'd7, O_FAULT,  0};
    tbl[33] = '{7'b0110000, 3'd7, O_FAULT,  0};
    tbl[34] = '{7'b0100000, 3'd7, O_FAULT,  0};
    tbl[35] = '{7'b1000000, 3'd0, O_NONE,   0};
    tbl[36] = '{7'b0000000, 3'd1, O_NONE,   0};
    for (int i = 0; i < 37; i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d state", i), 32'(bus.state), 32'(tbl[i].st));
      check($sformatf("vec%0d outputs", i), 32'(outs), 32'(tbl[i].out));
`ifdef CU_PERF_CNT_EN
      check($sformatf("vec%0d instr_count", i), instr_count, 32'(tbl[i].cnt));
`endif
    end
    step(7'b0010000);
    check("halt_entry state", 32'(bus.state), 32'd6);
    check("halt_entry outputs", 32'(outs), 32'(O_HALT));
    step(7'b1010000);
    check("rst_in_halt state", 32'(bus.state), 32'd0);
    check("rst_in_halt outputs", 32'(outs), 32'(O_NONE));
    step(7'b0000000);
    check("after_rst state", 32'(bus.state), 32'd1);
    cyc = 0;
    drive(7'b0000000);
    while (bus.state != 3'd7 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("timeout cycles", 32'(cyc), 32'd3);
    for (int k = 0; k < 4; k++) begin
      step({1'b0, k[0], k[1], 4'b1111});
      check($sformatf("fault_sticky%0d outputs", k), 32'(outs), 32'(O_FAULT));
    end
    step(7'b1000000);
    check("final_rst state", 32'(bus.state), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
